serial_command_issuer: RTL and testbench

Initiator side of the FPGA serial command protocol. Accepts one high-level command (NOP, INFO, UPLOAD, DOWNLOAD, FORCE_RST_HIGH, FORCE_RST_LOW), serializes the frame `{NUMBER_OF_WORDS, COMMAND, payload}` onto a byte-wide UART transmitter, and collects response words from the UART receiver. It is used on a host-side or test FPGA to drive the processor board's serial command port, and in benches as a protocol master.

---
 rtl/serial_command_issuer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_serial_command_issuer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_command_issuer.sv
// Initiator side of the FPGA serial command protocol: frames one command onto a byte UART
// and assembles response words. Define SCI_TIMEOUT_EN to abandon silent responses.
module serial_command_issuer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_code,
  input  logic [31:0] cmd_start_addr,
  input  logic [31:0] cmd_end_addr,
  input  logic [31:0] up_word,
  input  logic        up_valid,
  output logic        up_ready,
  output logic [31:0] rsp_word,
  output logic        rsp_valid,
  output logic [31:0] info_len,
  output logic [7:0]  TX,
  output logic        start_TX,
  input  logic        TX_ready,
  input  logic [7:0]  RX,
  input  logic        RX_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [31:0] CMD_INFO     = 32'd1;
  localparam logic [31:0] CMD_UPLOAD   = 32'd2;
  localparam logic [31:0] CMD_DOWNLOAD = 32'd3;
  localparam logic [31:0] CMD_LAST     = 32'd5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEND_LEN,
    S_SEND_CMD,
    S_SEND_START,
    S_SEND_END,
    S_SEND_DATA,
    S_RECV_LEN,
    S_RECV_DATA,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [31:0] cmd_q;
  logic [31:0] start_q;
  logic [31:0] end_q;
  logic [31:0] len_q;
  logic [31:0] words_left_q;
  logic [1:0]  byte_idx_q;
  logic        start_prev_q;
  logic [31:0] buf_q;
  logic        buf_full_q;
  logic [23:0] rx_shift_q;
  logic [1:0]  rx_idx_q;
  logic [31:0] rsp_word_q;
  logic        rsp_valid_q;
  logic [31:0] info_len_q;
  logic        done_q;
  logic        err_q;

`ifdef SCI_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmo_q;
`endif

  // Accept-time decode of the incoming request
  logic [31:0] span;
  logic [31:0] n_words;
  logic        is_xfer;
  logic        reject;
  logic [31:0] frame_len;

  assign span    = cmd_end_addr - cmd_start_addr;
  assign n_words = span >> 2;
  assign is_xfer = (cmd_code == CMD_UPLOAD) || (cmd_code == CMD_DOWNLOAD);
  assign reject  = (cmd_code > CMD_LAST) ||
                   (is_xfer && ((cmd_end_addr <= cmd_start_addr) || (span[1:0] != 2'b00)));

  always_comb begin
    frame_len = 32'd1;
    if (cmd_code == CMD_UPLOAD)        frame_len = n_words + 32'd3;
    else if (cmd_code == CMD_DOWNLOAD) frame_len = 32'd3;
  end

  // Byte transmitter: one strobe at most every other cycle, gated by TX_ready
  logic        send_state;
  logic        byte_avail;
  logic        last_byte;
  logic [31:0] tx_word;
  logic [7:0]  tx_byte;

  assign send_state = state_q inside {S_SEND_LEN, S_SEND_CMD, S_SEND_START, S_SEND_END, S_SEND_DATA};
  assign byte_avail = (state_q != S_SEND_DATA) || buf_full_q;
  assign start_TX   = send_state && byte_avail && TX_ready && !start_prev_q;
  assign last_byte  = start_TX && (byte_idx_q == 2'd3);
  assign TX         = start_TX ? tx_byte : '0;

  always_comb begin
    tx_word = '0;
    case (state_q)
      S_SEND_LEN:   tx_word = len_q;
      S_SEND_CMD:   tx_word = cmd_q;
      S_SEND_START: tx_word = start_q;
      S_SEND_END:   tx_word = end_q;
      S_SEND_DATA:  tx_word = buf_q;
      default:      tx_word = '0;
    endcase
    tx_byte = tx_word[31:24];
    case (byte_idx_q)
      2'd1:    tx_byte = tx_word[23:16];
      2'd2:    tx_byte = tx_word[15:8];
      2'd3:    tx_byte = tx_word[7:0];
      default: tx_byte = tx_word[31:24];
    endcase
  end

  // Receive assembly; bytes outside the receive states are dropped
  logic        recv_state;
  logic        recv_drained;
  logic        rx_take;
  logic        rx_full;
  logic [31:0] rx_word;

  assign recv_state   = (state_q == S_RECV_LEN) || (state_q == S_RECV_DATA);
  assign recv_drained = (state_q == S_RECV_DATA) && (words_left_q == '0);
  assign rx_take      = recv_state && !recv_drained && RX_ready;
  assign rx_full      = rx_take && (rx_idx_q == 2'd3);
  assign rx_word      = {rx_shift_q, RX};

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign up_ready  = (state_q == S_SEND_DATA) && !buf_full_q;
  assign rsp_word  = rsp_word_q;
  assign rsp_valid = rsp_valid_q;
  assign info_len  = info_len_q;
  assign done      = done_q;
  assign err       = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      start_q      <= '0;
      end_q        <= '0;
      len_q        <= '0;
      words_left_q <= '0;
      byte_idx_q   <= '0;
      start_prev_q <= 1'b0;
      buf_q        <= '0;
      buf_full_q   <= 1'b0;
      rx_shift_q   <= '0;
      rx_idx_q     <= '0;
      rsp_word_q   <= '0;
      rsp_valid_q  <= 1'b0;
      info_len_q   <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef SCI_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      start_prev_q <= start_TX;
      rsp_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      if (start_TX) byte_idx_q <= byte_idx_q + 2'd1;
      if (rx_take) begin
        rx_shift_q <= rx_word[23:0];
        rx_idx_q   <= rx_idx_q + 2'd1;
      end

      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_q        <= cmd_code;
            start_q      <= cmd_start_addr;
            end_q        <= cmd_end_addr;
            len_q        <= frame_len;
            words_left_q <= n_words;
            byte_idx_q   <= '0;
            rx_idx_q     <= '0;
            buf_full_q   <= 1'b0;
            if (reject) err_q   <= 1'b1;
            else        state_q <= S_SEND_LEN;
          end
        end
        S_SEND_LEN: if (last_byte) state_q <= S_SEND_CMD;
        S_SEND_CMD: begin
          if (last_byte) begin
            if ((cmd_q == CMD_UPLOAD) || (cmd_q == CMD_DOWNLOAD)) begin
              state_q <= S_SEND_START;
            end else if (cmd_q == CMD_INFO) begin
              state_q <= S_RECV_LEN;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_SEND_START: if (last_byte) state_q <= S_SEND_END;
        S_SEND_END: begin
          if (last_byte) state_q <= (cmd_q == CMD_UPLOAD) ? S_SEND_DATA : S_RECV_DATA;
        end
        S_SEND_DATA: begin
          if (up_valid && up_ready) begin
            buf_q      <= up_word;
            buf_full_q <= 1'b1;
          end
          if (last_byte) begin
            buf_full_q   <= 1'b0;
            words_left_q <= words_left_q - 32'd1;
            if (words_left_q == 32'd1) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_RECV_LEN: begin
          if (rx_full) begin
            info_len_q   <= rx_word;
            words_left_q <= rx_word;
            if (rx_word == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RECV_DATA;
            end
          end
        end
        // Last word leaves the count at zero; DONE follows one cycle after its rsp_valid
        S_RECV_DATA: begin
          if (recv_drained) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (rx_full) begin
            rsp_word_q   <= rx_word;
            rsp_valid_q  <= 1'b1;
            words_left_q <= words_left_q - 32'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

`ifdef SCI_TIMEOUT_EN
      if (recv_state && !recv_drained) begin
        if (RX_ready) begin
          tmo_q <= '0;
        end else if (tmo_q == TMO_LAST) begin
          tmo_q   <= '0;
          err_q   <= 1'b1;
          state_q <= S_IDLE;
        end else begin
          tmo_q <= tmo_q + 32'd1;
        end
      end else begin
        tmo_q <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_serial_command_issuer.sv
// Scoreboard bench for serial_command_issuer: expected TX bytes and response words are
// queued as stimulus is driven and checked as the DUT strobes them out.
module tb_serial_command_issuer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_code = '0;
  logic [31:0] cmd_start_addr = '0;
  logic [31:0] cmd_end_addr = '0;
  logic [31:0] up_word = '0;
  logic        up_valid = 1'b0;
  logic        up_ready;
  logic [31:0] rsp_word;
  logic        rsp_valid;
  logic [31:0] info_len;
  logic [7:0]  TX;
  logic        start_TX;
  logic        TX_ready = 1'b1;
  logic [7:0]  RX = '0;
  logic        RX_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  tx_exp[$];
  logic [31:0] rsp_exp[$];
  logic [31:0] up_q[$];
  int done_cnt = 0, err_cnt = 0, rsp_cnt = 0, up_hs = 0;
  int tx_extra = 0, rsp_extra = 0, spacing_bad = 0;
  logic throttle = 1'b0;
  logic prev_stb = 1'b0;

  serial_command_issuer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_start_addr(cmd_start_addr), .cmd_end_addr(cmd_end_addr),
    .up_word(up_word), .up_valid(up_valid), .up_ready(up_ready),
    .rsp_word(rsp_word), .rsp_valid(rsp_valid), .info_len(info_len),
    .TX(TX), .start_TX(start_TX), .TX_ready(TX_ready),
    .RX(RX), .RX_ready(RX_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor / scoreboard consumer
  always @(negedge clk) begin
    if (!rst) begin
      prev_stb = 1'b0;
    end else begin
      if (start_TX) begin
        if (prev_stb) spacing_bad++;
        if (tx_exp.size() == 0) tx_extra++;
        else check("tx_byte", {24'h0, TX}, {24'h0, tx_exp.pop_front()});
      end
      prev_stb = start_TX;
      if (rsp_valid) begin
        rsp_cnt++;
        if (rsp_exp.size() == 0) rsp_extra++;
        else check("rsp_word", rsp_word, rsp_exp.pop_front());
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    TX_ready = throttle ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Upload word source
  logic up_hs_now;
  always @(posedge clk) begin
    up_hs_now = up_valid && up_ready;
    #1;
    if (up_hs_now && up_q.size() != 0) begin
      void'(up_q.pop_front());
      up_hs++;
    end
    up_valid = (up_q.size() != 0);
    up_word  = up_valid ? up_q[0] : $urandom;
  end

  function automatic void push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) tx_exp.push_back(w[31-8*i -: 8]);
  endfunction

  task automatic issue(input logic [31:0] code, input logic [31:0] s, input logic [31:0] e,
                       input bit ok);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    check("ready_before_issue", {31'h0, cmd_ready}, 32'h1);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_code = code; cmd_start_addr = s; cmd_end_addr = e;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_code = $urandom; cmd_start_addr = $urandom; cmd_end_addr = $urandom;
    @(negedge clk); #1;
    if (ok) begin
      check("busy_t1", {31'h0, busy}, 32'h1);
      check("no_err_t1", {31'h0, err}, 32'h0);
      if (!throttle) check("first_stb_t1", {31'h0, start_TX}, 32'h1);
    end else begin
      check("rej_err_t1", {31'h0, err}, 32'h1);
      check("rej_no_stb", {31'h0, start_TX}, 32'h0);
      check("rej_ready_t1", {31'h0, cmd_ready}, 32'h1);
    end
  endtask

  task automatic wait_tx_drain(input string tag, input int budget);
    int n = 0;
    while (tx_exp.size() != 0 && n < budget) begin
      @(negedge clk); #1; n++;
    end
    check(tag, tx_exp.size(), 32'h0);
  endtask

  task automatic wait_done(input string tag, input int budget, input int exp_lat);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk); #1; n++;
    end
    check({tag, "_done_pulses"}, done_cnt - d0, 32'h1);
    if (exp_lat > 0) check({tag, "_done_latency"}, n, exp_lat);
    check({tag, "_busy_in_done"}, {31'h0, cmd_ready}, 32'h0);
    @(negedge clk); #1;
    check({tag, "_ready_after_done"}, {31'h0, cmd_ready}, 32'h1);
  endtask

  task automatic rx_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      RX = w[31-8*i -: 8]; RX_ready = 1'b1;
      @(posedge clk); #1;
      RX_ready = 1'b0; RX = $urandom;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    int n, e0, d0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_tx", {24'h0, TX}, 32'h0);
    check("rst_start_tx", {31'h0, start_TX}, 32'h0);
    check("rst_up_ready", {31'h0, up_ready}, 32'h0);
    check("rst_rsp_word", rsp_word, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_info_len", info_len, 32'h0);
    check("rst_done_err", {30'h0, done, err}, 32'h0);
    #2 rst = 1'b1;

    // INFO with 28 response words
    push_word(32'd1); push_word(32'd1);
    rsp_cnt = 0;
    issue(32'd1, '0, '0, 1'b1);
    wait_tx_drain("info_tx_drain", 200);
    rx_word(32'd28);
    for (int i = 0; i < 28; i++) begin
      w = $urandom;
      rsp_exp.push_back(w);
      rx_word(w);
    end
    wait_done("info", 100, 2);
    check("info_len", info_len, 32'd28);
    check("info_rsp_count", rsp_cnt, 32'd28);
    check("info_rsp_left", rsp_exp.size(), 32'h0);

    // UPLOAD with a stalling UART
    throttle = 1'b1;
    up_hs = 0;
    up_q.push_back(32'hDEADBEEF); up_q.push_back(32'h01234567);
    push_word(32'd5); push_word(32'd2); push_word(32'h100); push_word(32'h108);
    push_word(32'hDEADBEEF); push_word(32'h01234567);
    issue(32'd2, 32'h100, 32'h108, 1'b1);
    wait_tx_drain("upl_tx_drain", 1000);
    wait_done("upl", 20, 1);
    throttle = 1'b0;
    check("upl_handshakes", up_hs, 32'd2);

    // DOWNLOAD, with a stray RX byte while still transmitting
    rsp_cnt = 0;
    push_word(32'd3); push_word(32'd3); push_word(32'h0); push_word(32'hC);
    rsp_exp.push_back(32'hAABBCCDD); rsp_exp.push_back(32'h11223344); rsp_exp.push_back(32'h55667788);
    issue(32'd3, 32'h0, 32'hC, 1'b1);
    @(posedge clk); #1; RX = 8'hFF; RX_ready = 1'b1;
    @(posedge clk); #1; RX_ready = 1'b0;
    wait_tx_drain("dl_tx_drain", 200);
    rx_word(32'hAABBCCDD); rx_word(32'h11223344); rx_word(32'h55667788);
    wait_done("dl", 100, 2);
    check("dl_rsp_count", rsp_cnt, 32'd3);
    check("dl_rsp_left", rsp_exp.size(), 32'h0);

    // Rejections, then a transmit-only command
    e0 = err_cnt;
    issue(32'd3, 32'h10, 32'h10, 1'b0);
    issue(32'd2, 32'h0, 32'h6, 1'b0);
    issue(32'd7, 32'h0, 32'h0, 1'b0);
    check("rej_err_pulses", err_cnt - e0, 32'd3);
    check("rej_tx_extra", tx_extra, 32'h0);
    push_word(32'd1); push_word(32'd4);
    issue(32'd4, '0, '0, 1'b1);
    wait_tx_drain("frh_tx_drain", 200);
    wait_done("frh", 20, 1);

    // INFO with no response
    d0 = done_cnt;
    push_word(32'd1); push_word(32'd1);
    issue(32'd1, '0, '0, 1'b1);
    wait_tx_drain("tmo_tx_drain", 200);
`ifdef SCI_TIMEOUT_EN
    e0 = err_cnt; n = 0;
    while (err_cnt == e0 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    check("tmo_latency", n - 1, 32'd16);
    check("tmo_no_done", done_cnt - d0, 32'h0);
    check("tmo_ready", {31'h0, cmd_ready}, 32'h1);
`else
    repeat (1000) @(negedge clk);
    #1;
    check("notmo_still_busy", {31'h0, busy}, 32'h1);
    check("notmo_no_done", done_cnt - d0, 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
`endif

    // Reset after the 6th UPLOAD byte
    up_q.push_back(32'hCAFEF00D);
    push_word(32'd4); tx_exp.push_back(8'h00); tx_exp.push_back(8'h00);
    issue(32'd2, 32'h0, 32'h4, 1'b1);
    wait_tx_drain("rst_tx_drain", 200);
    rst = 1'b0;
    #1;
    check("midrst_start_tx", {31'h0, start_TX}, 32'h0);
    check("midrst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    check("midrst_up_ready", {31'h0, up_ready}, 32'h0);
    up_q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    push_word(32'd1); push_word(32'd0);
    issue(32'd0, '0, '0, 1'b1);
    wait_tx_drain("nop_tx_drain", 200);
    wait_done("nop", 20, 1);

    check("tx_extra", tx_extra, 32'h0);
    check("rsp_extra", rsp_extra, 32'h0);
    check("tx_spacing", spacing_bad, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
